ap_ctrl_seq_driver: RTL and testbench

Synthesizable initiator for the HLS block-level ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue). It sits between a host command port and one HLS kernel top. It issues a programmed number of kernel transactions, allows overlapped transactions up to a fixed in-flight depth, and measures per-transaction latency. It raises a one-cycle `finish` when the last completion has been accepted, which is the same `finish` the simulation monitors consume.

---
 rtl/ap_ctrl_seq_driver.sv | 166 ++++++++++++++++
 tb/tb_ap_ctrl_seq_driver.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_seq_driver.sv
// ap_ctrl_chain initiator: issues a programmed run of kernel transactions with bounded overlap.
// Define AP_CTRL_SEQ_DRIVER_STATS_EN to build the timestamp FIFO and latency statistics.
module ap_ctrl_seq_driver #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cont_allow,
    output logic             busy,
    output logic             finish,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err,
    output logic [CNT_W-1:0] lat_last,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max
);
    localparam int unsigned IW = $clog2(TS_DEPTH + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] starts_left;
    logic [CNT_W-1:0] dones_left;
    logic [IW-1:0]    inflight;
    logic             start_hs;
    logic             done_req;
    logic             done_hs;
    logic             err_ev;

    always_comb begin
        busy        = (state == RUN) || (state == DRAIN);
        finish      = (state == DONE);
        ap_start    = (state == RUN) && (starts_left != '0) && (inflight < IW'(TS_DEPTH));
        ap_continue = busy && cont_allow;
        start_hs    = ap_start && ap_ready;
        done_req    = ap_done && ap_continue;
        // A completion with nothing outstanding is flagged but never consumed.
        done_hs     = done_req && (inflight != '0);
        err_ev      = (ap_ready && !ap_start) || (done_req && (inflight == '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            starts_left <= '0;
            dones_left  <= '0;
            issued_cnt  <= '0;
            done_cnt    <= '0;
            inflight    <= '0;
            err         <= 1'b0;
        end else begin
            if (err_ev) begin
                err <= 1'b1;
            end
            if (start_hs) begin
                starts_left <= starts_left - ONE;
                issued_cnt  <= issued_cnt + ONE;
            end
            if (done_hs) begin
                dones_left <= dones_left - ONE;
                done_cnt   <= done_cnt + ONE;
            end
            case ({start_hs, done_hs})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase

            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        starts_left <= cmd_count;
                        dones_left  <= cmd_count;
                        issued_cnt  <= '0;
                        done_cnt    <= '0;
                        inflight    <= '0;
                        err         <= err_ev;
                        state       <= (cmd_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (start_hs && (starts_left == ONE)) begin
                        state <= (done_hs && (dones_left == ONE)) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (done_hs && (dones_left == ONE)) begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AP_CTRL_SEQ_DRIVER_STATS_EN
    localparam int unsigned PW = (TS_DEPTH > 1) ? $clog2(TS_DEPTH) : 1;

    logic [CNT_W-1:0] now;
    logic [CNT_W-1:0] ts_mem [TS_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_next;
    logic [PW-1:0]    rd_next;
    logic             stats_valid;
    logic [CNT_W-1:0] lat;

    always_comb begin
        wr_next = (wr_ptr == PW'(TS_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        rd_next = (rd_ptr == PW'(TS_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        // Modular subtraction keeps latency correct across wrap of now.
        lat     = now - ts_mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            now         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            stats_valid <= 1'b0;
            lat_last    <= '0;
            lat_min     <= '0;
            lat_max     <= '0;
        end else begin
            now <= now + ONE;
            if ((state == IDLE) && cmd_start) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                stats_valid <= 1'b0;
            end
            if (start_hs) begin
                ts_mem[wr_ptr] <= now;
                wr_ptr         <= wr_next;
            end
            if (done_hs) begin
                rd_ptr      <= rd_next;
                stats_valid <= 1'b1;
                lat_last    <= lat;
                if (!stats_valid || (lat < lat_min)) begin
                    lat_min <= lat;
                end
                if (!stats_valid || (lat > lat_max)) begin
                    lat_max <= lat;
                end
            end
        end
    end
`else
    always_comb begin
        lat_last = '0;
        lat_min  = '0;
        lat_max  = '0;
    end
`endif

endmodule

// File: tb/tb_ap_ctrl_seq_driver.sv
// Bench for ap_ctrl_seq_driver: cycle-accurate queue-based reference model, table of random runs
// and hand-written corner sequences. Latency expectations follow AP_CTRL_SEQ_DRIVER_STATS_EN.
module tb_ap_ctrl_seq_driver;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned TS_DEPTH = 4;
    localparam int          MOD      = 1 << CNT_W;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_start;
    logic [CNT_W-1:0] cmd_count;
    logic             cont_allow;
    logic             busy;
    logic             finish;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic             err;
    logic [CNT_W-1:0] lat_last;
    logic [CNT_W-1:0] lat_min;
    logic [CNT_W-1:0] lat_max;

    always #5 clock = ~clock;

    ap_ctrl_seq_driver #(.CNT_W(CNT_W), .TS_DEPTH(TS_DEPTH)) dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_count(cmd_count),
        .cont_allow(cont_allow), .busy(busy), .finish(finish), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .issued_cnt(issued_cnt), .done_cnt(done_cnt), .err(err),
        .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max)
    );

    int total = 0;
    int bad   = 0;
    int fin_seen = 0;

    // Reference model: run progress as counts, outstanding starts as a queue of timestamps.
    bit m_busy = 0, m_fin = 0, m_err = 0, m_sv = 0, last_cp = 0;
    int m_starts = 0, m_dones = 0, m_issued = 0, m_done_cnt = 0, m_now = 0;
    int m_last = 0, m_min = 0, m_max = 0;
    int q[$];

    typedef struct {
        int count;
        int pr;
        int pd;
        int pc;
        int exp_issued;
        int exp_done;
        int exp_err;
    } vec_t;

    function automatic bit exp_start();
        return m_busy && (m_starts > 0) && (q.size() < int'(TS_DEPTH));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("busy", busy, m_busy);
        chk("finish", finish, m_fin);
        chk("ap_start", ap_start, exp_start());
        chk("ap_continue", ap_continue, m_busy && cont_allow);
        chk("issued_cnt", issued_cnt, m_issued);
        chk("done_cnt", done_cnt, m_done_cnt);
        chk("err", err, m_err);
`ifdef AP_CTRL_SEQ_DRIVER_STATS_EN
        chk("lat_last", lat_last, m_last);
        chk("lat_min", lat_min, m_min);
        chk("lat_max", lat_max, m_max);
`else
        chk("lat_last", lat_last, 0);
        chk("lat_min", lat_min, 0);
        chk("lat_max", lat_max, 0);
`endif
    endtask

    task automatic model_edge();
        bit st, cp, ev, acc, was_fin, apc;
        int lat;
        if (reset) begin
            m_busy = 0; m_fin = 0; m_err = 0; m_sv = 0; last_cp = 0;
            m_starts = 0; m_dones = 0; m_issued = 0; m_done_cnt = 0; m_now = 0;
            m_last = 0; m_min = 0; m_max = 0;
            q.delete();
            return;
        end
        apc = m_busy && cont_allow;
        st  = exp_start() && ap_ready;
        cp  = ap_done && apc && (q.size() > 0);
        ev  = (ap_ready && !exp_start()) || (ap_done && apc && (q.size() == 0));
        was_fin = m_fin;
        m_fin   = 0;
        acc     = !m_busy && !was_fin && cmd_start;
        if (cp) begin
            lat = (m_now - q.pop_front() + MOD) % MOD;
            m_dones--;
            m_done_cnt++;
            m_last = lat;
            if (!m_sv || lat < m_min) m_min = lat;
            if (!m_sv || lat > m_max) m_max = lat;
            m_sv = 1;
        end
        if (st) begin
            q.push_back(m_now);
            m_starts--;
            m_issued++;
        end
        if (acc) begin
            m_issued = 0; m_done_cnt = 0; m_sv = 0; m_err = 0;
            q.delete();
            m_starts = int'(cmd_count);
            m_dones  = int'(cmd_count);
            if (cmd_count == 0) m_fin = 1;
            else m_busy = 1;
        end
        if (ev) m_err = 1;
        if (m_busy && m_dones == 0) begin
            m_busy = 0;
            m_fin  = 1;
        end
        m_now   = (m_now + 1) % MOD;
        last_cp = cp;
    endtask

    // Called at a negedge: model the coming posedge, then sample at the next negedge.
    task automatic tick();
        model_edge();
        @(negedge clock);
        if (finish) fin_seen++;
        check_outputs();
    endtask

    task automatic quiet();
        cmd_start = 0; ap_ready = 0; ap_done = 0; cont_allow = 0;
    endtask

    task automatic kernel_inputs(input int pr, input int pd, input int pc);
        ap_ready = exp_start() && (int'($urandom_range(0, 99)) < pr);
        if (!(ap_done && !last_cp)) begin
            ap_done = (q.size() > 0) && (int'($urandom_range(0, 99)) < pd);
        end
        cont_allow = int'($urandom_range(0, 99)) < pc;
    endtask

    task automatic finish_run(input int pr, input int pd, input int pc, input int budget);
        int c;
        c = 0;
        while (!m_fin && c < budget) begin
            kernel_inputs(pr, pd, pc);
            tick();
            c++;
        end
        quiet();
        tick();
    endtask

    task automatic start_cmd(input int count);
        fin_seen  = 0;
        cmd_count = CNT_W'(count);
        cmd_start = 1;
        tick();
        cmd_start = 0;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 100, 50, 100, 1, 1, 0};
        tbl[1] = '{5, 50, 50, 50, 5, 5, 0};
        tbl[2] = '{10, 100, 20, 100, 10, 10, 0};
        tbl[3] = '{17, 30, 70, 60, 17, 17, 0};
        tbl[4] = '{40, 90, 90, 90, 40, 40, 0};
        tbl[5] = '{25, 70, 40, 30, 25, 25, 0};
        tbl[6] = '{0, 50, 50, 50, 0, 0, 0};
        tbl[7] = '{60, 100, 100, 100, 60, 60, 0};

        reset = 1;
        cmd_count = '0;
        quiet();
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ap_continue", ap_continue, 0);
        chk("rst_lat_max", lat_max, 0);
        reset = 0;
        tick();

        // Single transaction, completion five edges after the start handshake.
        start_cmd(1);
        chk("s1_ap_start", ap_start, 1);
        ap_ready = 1; tick(); ap_ready = 0;
        repeat (4) tick();
        ap_done = 1; cont_allow = 1; tick(); ap_done = 0;
        chk("s1_finish", finish, 1);
        tick(); cont_allow = 0;
        chk("s1_issued", issued_cnt, 1);
        chk("s1_done", done_cnt, 1);
        chk("s1_err", err, 0);
        chk("s1_fin_pulses", fin_seen, 1);
`ifdef AP_CTRL_SEQ_DRIVER_STATS_EN
        chk("s1_lat_last", lat_last, 5);
        chk("s1_lat_min", lat_min, 5);
        chk("s1_lat_max", lat_max, 5);
`endif

        // Throttle at TS_DEPTH, then back-pressure on the completion side.
        start_cmd(10);
        for (int c = 0; c < 8; c++) begin
            ap_ready = exp_start();
            tick();
        end
        ap_ready = 0;
        chk("thr_issued", issued_cnt, TS_DEPTH);
        chk("thr_ap_start", ap_start, 0);
        ap_done = 1; cont_allow = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("bp_continue", ap_continue, 0);
            chk("bp_done_cnt", done_cnt, 0);
        end
        cont_allow = 1;
        for (int c = 0; c < 40 && !m_fin; c++) begin
            int prev;
            prev = m_done_cnt;
            ap_ready = exp_start();
            ap_done  = q.size() > 0;
            tick();
            chk("bp_rate", done_cnt, prev + 1);
        end
        quiet();
        tick();
        chk("thr_issued_end", issued_cnt, 10);
        chk("thr_done_end", done_cnt, 10);
        chk("thr_err", err, 0);
        chk("thr_fin_pulses", fin_seen, 1);

        // Protocol errors: stray ready in IDLE, completion with nothing outstanding.
        ap_ready = 1; tick(); ap_ready = 0;
        chk("perr_ready_err", err, 1);
        chk("perr_ready_issued", issued_cnt, 10);
        start_cmd(2);
        chk("perr_cleared", err, 0);
        ap_done = 1; cont_allow = 1; tick(); quiet();
        chk("perr_done_err", err, 1);
        chk("perr_done_cnt", done_cnt, 0);
        finish_run(100, 100, 100, 200);
        chk("perr_sticky", err, 1);
        chk("perr_run_done", done_cnt, 2);

        // Zero-count run.
        start_cmd(0);
        chk("zero_finish", finish, 1);
        chk("zero_ap_start", ap_start, 0);
        chk("zero_err_clear", err, 0);
        tick();
        chk("zero_busy", busy, 0);

        // Latency across wrap of the 8-bit cycle counter.
        for (int c = 0; c < 300 && m_now != 248; c++) tick();
        start_cmd(1);
        tick();
        ap_ready = 1; tick(); ap_ready = 0;
        for (int c = 0; c < 300 && m_now != 4; c++) tick();
        ap_done = 1; cont_allow = 1; tick(); quiet();
`ifdef AP_CTRL_SEQ_DRIVER_STATS_EN
        chk("wrap_lat_last", lat_last, 10);
`endif
        tick();
        chk("wrap_fin_pulses", fin_seen, 1);

        // Reset in the middle of a run.
        start_cmd(6);
        for (int c = 0; c < 3; c++) begin
            ap_ready = 1;
            tick();
        end
        ap_ready = 0;
        chk("mr_issued_before", issued_cnt, 3);
        fin_seen = 0;
        reset = 1; tick(); reset = 0;
        chk("mr_busy", busy, 0);
        chk("mr_issued", issued_cnt, 0);
        chk("mr_ap_start", ap_start, 0);
        tick(); tick();
        chk("mr_no_finish", fin_seen, 0);
        start_cmd(6);
        finish_run(80, 60, 70, 2000);
        chk("mr_rerun_done", done_cnt, 6);
        chk("mr_rerun_fin", fin_seen, 1);

        // Randomised runs from the table.
        for (int i = 0; i < 8; i++) begin
            start_cmd(tbl[i].count);
            finish_run(tbl[i].pr, tbl[i].pd, tbl[i].pc, 4000);
            chk("tbl_issued", issued_cnt, tbl[i].exp_issued);
            chk("tbl_done", done_cnt, tbl[i].exp_done);
            chk("tbl_err", err, tbl[i].exp_err);
            chk("tbl_fin_pulses", fin_seen, 1);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
